// File: rtl/seg_pkg.sv
// Segment constants and shared types for the seven-segment scan driver.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;

  // Active-high {g,f,e,d,c,b,a} patterns for decimal digits.
  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus: packed digits and display controls in, digit/segment drives out.
//   nums[15:0]  digit3..digit0 nibbles
//   lz_en       leading-zero blanking
//   dp_mask     per-digit decimal point
//   blink_en    whole-display blink
//   an/seg/dp   digit enables, segments {g..a}, decimal point
interface seven_seg_scan_if;

  logic [15:0] nums;
  logic        lz_en;
  logic [3:0]  dp_mask;
  logic        blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output nums, lz_en, dp_mask, blink_en,
    input  an, seg, dp
  );

  modport slave (
    input  nums, lz_en, dp_mask, blink_en,
    output an, seg, dp
  );

endinterface

// File: rtl/seg_decoder.sv
// 4-bit value to active-high segment pattern; 10..15 show a dash.
//   value   digit value
//   pattern {g,f,e,d,c,b,a}, active high
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (value)
      4'd0:    pattern = SEG_PAT[0];
      4'd1:    pattern = SEG_PAT[1];
      4'd2:    pattern = SEG_PAT[2];
      4'd3:    pattern = SEG_PAT[3];
      4'd4:    pattern = SEG_PAT[4];
      4'd5:    pattern = SEG_PAT[5];
      4'd6:    pattern = SEG_PAT[6];
      4'd7:    pattern = SEG_PAT[7];
      4'd8:    pattern = SEG_PAT[8];
      4'd9:    pattern = SEG_PAT[9];
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment driver with per-scan snapshot,
// leading-zero blanking, decimal points and whole-display blink.
//   clk, rst  clock, asynchronous active-high reset
//   bus       seven_seg_scan_if slave (nums/controls in, an/seg/dp out)
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLINK_SCANS = 125,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_SCANS - 1);

  localparam logic [3:0] AN_IDLE  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_IDLE  = ACTIVE_LOW;

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          scan_done;
  logic [3:0]    digit;
  logic [6:0]    pat;
  logic          blank;
  logic          dark;
  logic [3:0]    an_hi;
  logic [6:0]    seg_hi;
  logic          dp_hi;

  seg_decoder u_dec (
    .value   (digit),
    .pattern (pat)
  );

  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    scan_done = tick && (idx_q == 2'd3);

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;

    // Snapshot once after reset, then only when entering slot 0.
    snap_d = snap_q;
    pend_d = pend_q;
    if (pend_q) begin
      snap_d = bus.nums;
      pend_d = 1'b0;
    end else if (scan_done) begin
      snap_d = bus.nums;
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (scan_done) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    digit = '0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = snap_q[3:0];
      2'd1: digit = snap_q[7:4];
      2'd2: digit = snap_q[11:8];
      2'd3: digit = snap_q[15:12];
      default: digit = '0;
    endcase

    if (bus.lz_en) begin
      case (idx_q)
        2'd3: blank = (snap_q[15:12] == 4'd0);
        2'd2: blank = (snap_q[15:8] == 8'd0);
        2'd1: blank = (snap_q[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end

    dark   = blank || (bus.blink_en && phase_q);
    an_hi  = dark ? 4'h0 : (4'b0001 << idx_q);
    seg_hi = dark ? SEG_OFF : pat;
    dp_hi  = !dark && bus.dp_mask[idx_q];

    an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d  = ACTIVE_LOW ? ~dp_hi  : dp_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b1;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= AN_IDLE;
      seg_q   <= SEG_IDLE;
      dp_q    <= DP_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
